dest_drain: RTL
===============

DEST_DRAIN -- requirements
Module: dest_drain

Interface
REQ-001 Parameters SHALL be: NPORT, default 4, number of destination ports; LANE_W, default 16, addr/data lane width per port; DEPTH, default 2, entries per port buffer; CNT_W, default 16, receive counter width.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 addr_out  input  NPORT*LANE_W  switch destination address lanes; port p occupies bits [p*LANE_W +: LANE_W].
REQ-005 data_out  input  NPORT*LANE_W  switch destination data lanes, same packing.
REQ-006 data_rdy  input  NPORT  switch has a word pending on port p.
REQ-007 rd_en  output  NPORT  registered read strobe to the switch, one per port.
REQ-008 out_valid  output  1  merged stream word available.
REQ-009 out_ready  input  1  downstream accepts the word; transfer when out_valid && out_ready.
REQ-010 out_port  output  2  source port of the current word.
REQ-011 out_addr, out_data  output  LANE_W each  address and data of the current word.
REQ-012 cnt_clr  input  1  synchronous clear of all receive counters.
REQ-013 rx_cnt  output  NPORT*CNT_W  per-port count of captured words, same lane packing.

Function
REQ-014 Each port SHALL run an independent FSM: IDLE, REQ, CAP.
REQ-015 IDLE->REQ when data_rdy[p]=1 and port buffer count < DEPTH; otherwise stay in IDLE.
REQ-016 In REQ, rd_en[p] SHALL be 1 for exactly that cycle; REQ->CAP unconditionally.
REQ-017 In CAP, the port lane of addr_out/data_out SHALL be pushed into the port buffer and rx_cnt[p] incremented; CAP->IDLE unconditionally.
REQ-018 Timing: data_rdy sampled at edge N gives rd_en high in cycle N+1 and capture at edge N+2; at most one outstanding read per port, so max 1 word per 3 cycles per port.
REQ-019 Buffers SHALL be FIFO order; a push and a pop in the same cycle SHALL both occur and leave the count unchanged; the buffer SHALL never overflow, because the IDLE check covers the single outstanding read.
REQ-020 out_valid SHALL be 1 when any buffer is non-empty; out_port/out_addr/out_data SHALL show the head of the granted port.
REQ-021 Arbitration SHALL be round-robin: search starts at pointer ptr; after a transfer from port p, ptr = (p+1) mod NPORT; ptr resets to 0.
REQ-022 While out_valid && !out_ready, the grant and all out_* fields SHALL stay stable.
REQ-023 rx_cnt[p] SHALL saturate at all-ones; cnt_clr set with a capture in the same cycle SHALL give 0, because clear wins.
REQ-024 data_rdy dropping while a port is in REQ/CAP SHALL NOT abort the sequence; the lane is still captured in CAP.

Reset
REQ-025 While reset=0: all FSMs IDLE, rd_en=0, buffers empty, out_valid=0, out_port=0, out_addr=0, out_data=0, ptr=0, rx_cnt=0.
REQ-026 Reset asserted mid-sequence SHALL discard any in-flight read and all buffered words immediately; no rd_en pulse after assertion.
REQ-027 After reset deasserts, the first rd_en SHALL appear no earlier than the second rising edge.

Structure
REQ-028 A shared package SHALL hold NPORT, LANE_W, the FSM state enum (IDLE/REQ/CAP) and a word struct {addr, data}.
REQ-029 Per-port FSM, buffer and counter SHALL be a sub-module drain_lane, instantiated NPORT times; dest_drain adds only the arbiter and output mux.

Verification
REQ-030 Scenario: port 1 data_rdy held, lane = addr 0x0011/data 0xBEEF, out_ready=1 -> rd_en[1] pulses once every 3 cycles; out_port=1, out_addr=0x0011, out_data=0xBEEF; rx_cnt[1] counts 1,2,3.
REQ-031 Scenario: all four ports ready, out_ready=1 -> out_port sequence 0,1,2,3,0,... and no port is granted twice in a row while others are pending.
REQ-032 Scenario: out_ready=0, port 2 data_rdy held -> exactly DEPTH=2 rd_en[2] pulses, then none; out_* stable; raising out_ready drains both words in capture order.
REQ-033 Scenario: rx_cnt[0] preset to 0xFFFE, 3 captures -> 0xFFFF, 0xFFFF, 0xFFFF; cnt_clr with a capture in the same cycle -> 0.
REQ-034 Scenario: reset=0 during port 3 REQ -> rd_en=0, out_valid=0, rx_cnt=0 that cycle; no capture after release until new data_rdy.
REQ-035 Scenario: data_rdy[0] pulsed 1 cycle only -> full REQ/CAP sequence, one word captured.

Source files
------------

// File: rtl/dest_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dest_drain_pkg
// Purpose  : Shared constants and types for the destination drain block.
//            Holds the default port count and lane widths, the per-port
//            read-sequence state encoding and the buffered word layout.
// Revision : 1.0  initial release
// ============================================================================
package dest_drain_pkg;

    localparam int NPORT  = 4;   // destination ports
    localparam int LANE_W = 16;  // addr/data lane width per port
    localparam int DEPTH  = 2;   // entries per port buffer
    localparam int CNT_W  = 16;  // receive counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CAP  = 2'd2
    } lane_state_e;

    typedef struct packed {
        logic [LANE_W-1:0] addr;
        logic [LANE_W-1:0] data;
    } word_t;

endpackage
`default_nettype wire

// File: rtl/dest_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : dest_drain_if
// Purpose  : Bundles the switch-side read interface and the merged output
//            stream of the destination drain.
// Ports    : addr_out/data_out/data_rdy  switch lanes into the drain
//            rd_en                       read strobes back to the switch
//            out_valid/out_ready         merged stream handshake
//            out_port/out_addr/out_data  merged stream word
// Modports : master - the drain itself; slave - switch plus downstream sink
// Revision : 1.0  initial release
// ============================================================================
interface dest_drain_if #(
    parameter int NPORT  = dest_drain_pkg::NPORT,
    parameter int LANE_W = dest_drain_pkg::LANE_W
);
    localparam int PORT_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    logic [NPORT*LANE_W-1:0] addr_out;
    logic [NPORT*LANE_W-1:0] data_out;
    logic [NPORT-1:0]        data_rdy;
    logic [NPORT-1:0]        rd_en;
    logic                    out_valid;
    logic                    out_ready;
    logic [PORT_W-1:0]       out_port;
    logic [LANE_W-1:0]       out_addr;
    logic [LANE_W-1:0]       out_data;

    modport master (
        input  addr_out, data_out, data_rdy, out_ready,
        output rd_en, out_valid, out_port, out_addr, out_data
    );

    modport slave (
        output addr_out, data_out, data_rdy, out_ready,
        input  rd_en, out_valid, out_port, out_addr, out_data
    );
endinterface
`default_nettype wire

// File: rtl/dest_drain_lane.sv
`default_nettype none
// ============================================================================
// Module   : drain_lane
// Purpose  : One destination port: IDLE/REQ/CAP read sequencer, FIFO buffer
//            and saturating receive counter.
// Ports    : clk, rst_n       clock, asynchronous active-low reset
//            i_data_rdy       switch has a word pending on this port
//            i_lane           this port's addr/data lane
//            i_pop            arbiter consumes the buffer head
//            i_cnt_clr        synchronous counter clear
//            o_rd_en          registered read strobe
//            o_head           buffer head word
//            o_nonempty       buffer holds at least one word
//            o_rx_cnt         captured-word count
// Revision : 1.0  initial release
// ============================================================================
module drain_lane import dest_drain_pkg::*; #(
    parameter int DEPTH = dest_drain_pkg::DEPTH,
    parameter int CNT_W = dest_drain_pkg::CNT_W
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_data_rdy,
    input  wire word_t            i_lane,
    input  wire logic             i_pop,
    input  wire logic             i_cnt_clr,
    output logic                  o_rd_en,
    output word_t                 o_head,
    output logic                  o_nonempty,
    output logic [CNT_W-1:0]      o_rx_cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCW   = $clog2(DEPTH + 1);

    lane_state_e      r_state;
    logic             r_rd_en;
    logic             r_armed;
    word_t            r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [FCW-1:0]   r_count;
    logic [CNT_W-1:0] r_rx_cnt;
    logic             w_push;

    assign w_push = (r_state == ST_CAP);

    // r_armed holds off the first request until one full edge after reset
    // release. Because only one read is ever outstanding, checking the
    // occupancy in IDLE is enough to guarantee room for the captured word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rd_en <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            r_rd_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_armed && i_data_rdy && (r_count < FCW'(DEPTH))) begin
                        r_state <= ST_REQ;
                        r_rd_en <= 1'b1;
                    end
                end
                ST_REQ:  r_state <= ST_CAP;
                ST_CAP:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_lane;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, i_pop})
                2'b10:   r_count <= r_count + FCW'(1);
                2'b01:   r_count <= r_count - FCW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear takes priority over a simultaneous capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_rx_cnt <= '0;
        end else if (w_push && (r_rx_cnt != '1)) begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
        end
    end

    assign o_rd_en    = r_rd_en;
    assign o_head     = r_mem[r_rd_ptr];
    assign o_nonempty = (r_count != '0);
    assign o_rx_cnt   = r_rx_cnt;
endmodule
`default_nettype wire

// File: rtl/dest_drain.sv
`default_nettype none
// ============================================================================
// Module   : dest_drain
// Purpose  : Drains NPORT switch destination ports into one merged stream.
//            Each port runs its own drain_lane; this level arbitrates the
//            buffer heads round-robin and muxes the granted word out.
// Ports    : clk, rst_n   clock, asynchronous active-low reset
//            bus          dest_drain_if master (switch lanes + out stream)
//            cnt_clr      synchronous clear of all receive counters
//            rx_cnt       per-port receive counts, CNT_W per port
// Revision : 1.0  initial release
// ============================================================================
module dest_drain import dest_drain_pkg::*; #(
    parameter int NPORT  = dest_drain_pkg::NPORT,
    parameter int LANE_W = dest_drain_pkg::LANE_W,
    parameter int DEPTH  = dest_drain_pkg::DEPTH,
    parameter int CNT_W  = dest_drain_pkg::CNT_W
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    dest_drain_if.master            bus,
    input  wire logic               cnt_clr,
    output logic [NPORT*CNT_W-1:0]  rx_cnt
);
    localparam int PORT_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    word_t             w_head [NPORT];
    logic [NPORT-1:0]  w_nonempty;
    logic [NPORT-1:0]  w_rd_en;
    logic [NPORT-1:0]  w_pop;
    logic [PORT_W-1:0] r_ptr;
    logic              r_hold;
    logic [PORT_W-1:0] r_hold_port;
    logic [PORT_W-1:0] w_search;
    logic [PORT_W-1:0] w_idx;
    logic              w_found;
    logic [PORT_W-1:0] w_grant;
    logic              w_valid;
    logic              w_xfer;

    generate
        for (genvar p = 0; p < NPORT; p++) begin : g_lane
            word_t w_lane;
            assign w_lane.addr = bus.addr_out[p*LANE_W +: LANE_W];
            assign w_lane.data = bus.data_out[p*LANE_W +: LANE_W];
            assign w_pop[p]    = w_xfer && (w_grant == PORT_W'(p));

            drain_lane #(
                .DEPTH (DEPTH),
                .CNT_W (CNT_W)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_data_rdy (bus.data_rdy[p]),
                .i_lane     (w_lane),
                .i_pop      (w_pop[p]),
                .i_cnt_clr  (cnt_clr),
                .o_rd_en    (w_rd_en[p]),
                .o_head     (w_head[p]),
                .o_nonempty (w_nonempty[p]),
                .o_rx_cnt   (rx_cnt[p*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // First non-empty port at or after the round-robin pointer.
    always_comb begin
        w_search = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NPORT; k++) begin
            w_idx = PORT_W'((int'(r_ptr) + k) % NPORT);
            if (!w_found && w_nonempty[w_idx]) begin
                w_found  = 1'b1;
                w_search = w_idx;
            end
        end
    end

    // A stalled word keeps its grant even if a port ahead of it in the
    // search order fills up meanwhile, so the output never changes under
    // back-pressure.
    assign w_grant = r_hold ? r_hold_port : w_search;
    assign w_valid = |w_nonempty;
    assign w_xfer  = w_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_hold      <= 1'b0;
            r_hold_port <= '0;
        end else begin
            r_hold      <= w_valid && !bus.out_ready;
            r_hold_port <= w_grant;
            if (w_xfer) begin
                r_ptr <= (w_grant == PORT_W'(NPORT - 1)) ? '0 : w_grant + PORT_W'(1);
            end
        end
    end

    assign bus.rd_en     = w_rd_en;
    assign bus.out_valid = w_valid;
    assign bus.out_port  = w_valid ? w_grant : '0;
    assign bus.out_addr  = w_valid ? w_head[w_grant].addr : '0;
    assign bus.out_data  = w_valid ? w_head[w_grant].data : '0;
endmodule
`default_nettype wire
